// File: rtl/lcd_spi_write.sv
// Serialises one 9-bit {dc, byte} LCD word onto a 4-wire SPI bus (mode 0, MSB first),
// pulses wr_done per byte and then holds off for a fixed gap before accepting the next.
module lcd_spi_write #(
   parameter int unsigned CLK_DIV    = 2,
   parameter int unsigned GAP_CYCLES = 4
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic [8:0] write_data,
   input  logic       en_write,
   output logic       wr_done,
   output logic       busy,
   output logic       lcd_cs_n,
   output logic       lcd_sclk,
   output logic       lcd_mosi,
   output logic       lcd_dc
);

   localparam int unsigned DIV_W = 8;
   localparam int unsigned BIT_W = 3;
   localparam int unsigned GAP_W = 4;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;
   localparam logic [1:0] GAP   = 2'd3;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

   logic [1:0]       state,     state_nxt;
   logic [7:0]       shift_reg, shift_nxt;
   logic [DIV_W-1:0] div_cnt,   div_nxt;
   logic [BIT_W-1:0] bit_cnt,   bit_nxt;
   logic [GAP_W-1:0] gap_cnt,   gap_nxt;
   logic             done_nxt, busy_nxt, cs_nxt, sclk_nxt, mosi_nxt, dc_nxt;

   // State and registered bus outputs
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state     <= IDLE;
         shift_reg <= '0;
         div_cnt   <= '0;
         bit_cnt   <= '0;
         gap_cnt   <= '0;
         wr_done   <= 1'b0;
         busy      <= 1'b0;
         lcd_cs_n  <= 1'b1;
         lcd_sclk  <= 1'b0;
         lcd_mosi  <= 1'b0;
         lcd_dc    <= 1'b0;
      end else begin
         state     <= state_nxt;
         shift_reg <= shift_nxt;
         div_cnt   <= div_nxt;
         bit_cnt   <= bit_nxt;
         gap_cnt   <= gap_nxt;
         wr_done   <= done_nxt;
         busy      <= busy_nxt;
         lcd_cs_n  <= cs_nxt;
         lcd_sclk  <= sclk_nxt;
         lcd_mosi  <= mosi_nxt;
         lcd_dc    <= dc_nxt;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_nxt = state;
      shift_nxt = shift_reg;
      div_nxt   = div_cnt;
      bit_nxt   = bit_cnt;
      gap_nxt   = gap_cnt;
      done_nxt  = 1'b0;
      cs_nxt    = lcd_cs_n;
      sclk_nxt  = lcd_sclk;
      mosi_nxt  = lcd_mosi;
      dc_nxt    = lcd_dc;

      case (state)
         IDLE: begin
            if (en_write) begin
               state_nxt = SHIFT;
               shift_nxt = write_data[7:0];
               dc_nxt    = write_data[8];
               cs_nxt    = 1'b0;
               mosi_nxt  = write_data[7];
               sclk_nxt  = 1'b0;
               bit_nxt   = BIT_W'(7);
               div_nxt   = '0;
            end
         end
         SHIFT: begin
            if (div_cnt == DIV_LAST) begin
               div_nxt = '0;
               if (!lcd_sclk) begin
                  sclk_nxt = 1'b1;
               end else if (bit_cnt == '0) begin
                  state_nxt = DONE;
                  sclk_nxt  = 1'b0;
                  cs_nxt    = 1'b1;
                  done_nxt  = 1'b1;
               end else begin
                  // falling SCLK edge: present the next lower bit
                  sclk_nxt = 1'b0;
                  bit_nxt  = bit_cnt - BIT_W'(1);
                  mosi_nxt = shift_reg[bit_cnt - BIT_W'(1)];
               end
            end else begin
               div_nxt = div_cnt + DIV_W'(1);
            end
         end
         DONE: begin
            state_nxt = GAP;
            gap_nxt   = '0;
         end
         GAP: begin
            if (gap_cnt == GAP_LAST) begin
               state_nxt = IDLE;
            end else begin
               gap_nxt = gap_cnt + GAP_W'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase

      busy_nxt = (state_nxt != IDLE);
   end

endmodule

// File: tb/tb_lcd_spi_write.sv
// Scoreboard bench for lcd_spi_write: stimulus queues expected words, per-DUT monitors
// rebuild each byte from MOSI on SCLK rises and compare on wr_done.
module tb_lcd_spi_write;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [8:0] wd, wd2;
   logic       en, en2;
   logic       done1, busy1, cs1, sclk1, mosi1, dc1;
   logic       done2, busy2, cs2, sclk2, mosi2, dc2;

   int vecs = 0;
   int errs = 0;
   int cyc  = 0;

   logic [8:0] q1[$];
   logic [8:0] q2[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   lcd_spi_write #(.CLK_DIV(2), .GAP_CYCLES(4)) dut1 (
      .sys_clk(clk), .sys_rst_n(rst_n), .write_data(wd), .en_write(en),
      .wr_done(done1), .busy(busy1), .lcd_cs_n(cs1), .lcd_sclk(sclk1),
      .lcd_mosi(mosi1), .lcd_dc(dc1));

   lcd_spi_write #(.CLK_DIV(1), .GAP_CYCLES(3)) dut2 (
      .sys_clk(clk), .sys_rst_n(rst_n), .write_data(wd2), .en_write(en2),
      .wr_done(done2), .busy(busy2), .lcd_cs_n(cs2), .lcd_sclk(sclk2),
      .lcd_mosi(mosi2), .lcd_dc(dc2));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor for dut1 (CLK_DIV=2: wr_done 32 cycles after CS falls)
   logic [7:0] cap1;
   logic [8:0] e1;
   logic       prev_sclk1, prev_cs1;
   int         rises1 = 0, start1 = 0, last_done1 = 0, done_cnt1 = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         cap1 = '0; rises1 = 0; prev_sclk1 = 1'b0; prev_cs1 = 1'b1;
      end else begin
         if (!cs1 && prev_cs1) start1 = cyc;
         if (sclk1 && !prev_sclk1) begin
            cap1 = {cap1[6:0], mosi1};
            rises1++;
         end
         if (done1) begin
            if (q1.size() == 0) chk("unexpected_done1", 32'd1, 32'd0);
            else begin
               e1 = q1.pop_front();
               chk("word1", 32'({dc1, cap1}), 32'(e1));
               chk("rises1", 32'(rises1), 32'd8);
               chk("latency1", 32'(cyc - start1), 32'd32);
            end
            rises1 = 0; last_done1 = cyc; done_cnt1++;
         end
         prev_sclk1 = sclk1; prev_cs1 = cs1;
      end
   end

   // Monitor for dut2 (CLK_DIV=1: wr_done 16 cycles after CS falls)
   logic [7:0] cap2;
   logic [8:0] e2;
   logic       prev_sclk2, prev_cs2;
   int         rises2 = 0, start2 = 0, last_done2 = 0, done_cnt2 = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         cap2 = '0; rises2 = 0; prev_sclk2 = 1'b0; prev_cs2 = 1'b1;
      end else begin
         if (!cs2 && prev_cs2) start2 = cyc;
         if (sclk2 && !prev_sclk2) begin
            cap2 = {cap2[6:0], mosi2};
            rises2++;
         end
         if (done2) begin
            if (q2.size() == 0) chk("unexpected_done2", 32'd1, 32'd0);
            else begin
               e2 = q2.pop_front();
               chk("word2", 32'({dc2, cap2}), 32'(e2));
               chk("rises2", 32'(rises2), 32'd8);
               chk("latency2", 32'(cyc - start2), 32'd16);
            end
            rises2 = 0; last_done2 = cyc; done_cnt2++;
         end
         prev_sclk2 = sclk2; prev_cs2 = cs2;
      end
   end

   // Wait for the next wr_done of the selected DUT, bounded by budget cycles
   task automatic wait_done(input int which, input int budget, output int t);
      int n0;
      n0 = (which == 1) ? done_cnt1 : done_cnt2;
      t  = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk); #1;
         if (((which == 1) ? done_cnt1 : done_cnt2) != n0) begin
            t = (which == 1) ? last_done1 : last_done2;
            return;
         end
      end
      chk("wr_done_timeout", 32'd0, 32'd1);
   endtask

   logic [8:0] pic[7];
   int t, tp, n0;

   initial begin
      rst_n = 1'b0; en = 1'b0; en2 = 1'b0; wd = '0; wd2 = '0;
      pic = '{9'h02C, 9'h1F8, 9'h100, 9'h107, 9'h1E0, 9'h1AB, 9'h1CD};
      repeat (3) @(negedge clk);
      #1;
      chk("reset_out1", 32'({done1, busy1, cs1, sclk1, mosi1, dc1}), 32'b001000);
      chk("reset_out2", 32'({done2, busy2, cs2, sclk2, mosi2, dc2}), 32'b001000);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      #1;

      // single command byte, en_write pulsed
      wd = 9'h02C; en = 1'b1; q1.push_back(9'h02C);
      @(negedge clk); #1;
      en = 1'b0;
      wait_done(1, 100, t);
      repeat (10) @(negedge clk);
      #1;
      chk("idle_after_pulse", 32'({busy1, cs1, sclk1}), 32'b010);

      // en_write held, data updated 2 cycles after each wr_done
      wd = 9'h1BC; en = 1'b1; q1.push_back(9'h1BC);
      wait_done(1, 100, tp);
      repeat (2) @(negedge clk);
      #1;
      wd = 9'h155; q1.push_back(9'h155);
      wait_done(1, 100, t);
      chk("period_38_a", 32'(t - tp), 32'd38);
      tp = t;
      repeat (2) @(negedge clk);
      #1;
      wd = 9'h0F0; q1.push_back(9'h0F0);
      wait_done(1, 100, t);
      chk("period_38_b", 32'(t - tp), 32'd38);
      repeat (2) @(negedge clk);
      #1;
      en = 1'b0;
      repeat (10) @(negedge clk);
      #1;

      // en_write dropped and data changed mid-byte
      wd = 9'h0E7; en = 1'b1; q1.push_back(9'h0E7);
      @(negedge clk); #1;
      repeat (9) @(negedge clk);
      #1;
      wd = 9'h111; en = 1'b0;
      n0 = done_cnt1;
      wait_done(1, 100, t);
      repeat (20) @(negedge clk);
      #1;
      chk("one_done_after_drop", 32'(done_cnt1 - n0), 32'd1);
      chk("idle_after_drop", 32'({busy1, cs1, sclk1}), 32'b010);
      chk("no_sclk_after_drop", 32'(rises1), 32'd0);

      // reset mid-byte aborts
      wd = 9'h1AA; en = 1'b1;
      @(negedge clk); #1;
      en = 1'b0;
      repeat (14) @(negedge clk);
      #1;
      n0 = done_cnt1;
      rst_n = 1'b0;
      #1;
      chk("abort_bus_idle", 32'({done1, busy1, cs1, sclk1, mosi1, dc1}), 32'b001000);
      repeat (2) @(negedge clk);
      #1;
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      #1;
      chk("no_done_on_abort", 32'(done_cnt1 - n0), 32'd0);
      wd = 9'h1C3; en = 1'b1; q1.push_back(9'h1C3);
      @(negedge clk); #1;
      en = 1'b0;
      wait_done(1, 100, t);

      // CLK_DIV=1, GAP_CYCLES=3: short show-pic style stream on dut2
      n0 = done_cnt2;
      wd2 = pic[0]; en2 = 1'b1;
      for (int i = 0; i < 7; i++) begin
         q2.push_back(pic[i]);
         wait_done(2, 60, t);
         if (i > 0) chk("period_21", 32'(t - tp), 32'd21);
         tp = t;
         repeat (2) @(negedge clk);
         #1;
         if (i < 6) wd2 = pic[i + 1];
         else en2 = 1'b0;
      end
      repeat (20) @(negedge clk);
      #1;
      chk("pic_done_count", 32'(done_cnt2 - n0), 32'd7);
      chk("q1_drained", 32'(q1.size()), 32'd0);
      chk("q2_drained", 32'(q2.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
